// File: rtl/zone_reader_pkg.sv
// Shared widths, packed-field positions and FSM encoding for the zone reader.
package zone_reader_pkg;

  localparam int H_W    = 11;
  localparam int V_W    = 10;
  localparam int HOR_W  = 2 * H_W;
  localparam int VERT_W = 2 * V_W;
  localparam int ZN     = 4;
  localparam int ZIDX_W = 2;

  // hor = {left, right}, vert = {top, bottom}
  localparam int HOR_L_MSB  = HOR_W - 1;
  localparam int HOR_L_LSB  = H_W;
  localparam int HOR_R_MSB  = H_W - 1;
  localparam int HOR_R_LSB  = 0;
  localparam int VERT_T_MSB = VERT_W - 1;
  localparam int VERT_T_LSB = V_W;
  localparam int VERT_B_MSB = V_W - 1;
  localparam int VERT_B_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SNAP = 2'd1,
    CALC = 2'd2,
    EMIT = 2'd3
  } state_t;

  function automatic logic [H_W-1:0] hor_left(input logic [HOR_W-1:0] h);
    return h[HOR_L_MSB:HOR_L_LSB];
  endfunction

  function automatic logic [H_W-1:0] hor_right(input logic [HOR_W-1:0] h);
    return h[HOR_R_MSB:HOR_R_LSB];
  endfunction

  function automatic logic [V_W-1:0] vert_top(input logic [VERT_W-1:0] v);
    return v[VERT_T_MSB:VERT_T_LSB];
  endfunction

  function automatic logic [V_W-1:0] vert_bottom(input logic [VERT_W-1:0] v);
    return v[VERT_B_MSB:VERT_B_LSB];
  endfunction

endpackage

// File: rtl/zone_centre.sv
// Combinational zone centre: occupancy test, midpoint, and origin-relative clamp.
module zone_centre
  import zone_reader_pkg::*;
(
  input  logic [H_W-1:0] l,
  input  logic [H_W-1:0] r,
  input  logic [V_W-1:0] t,
  input  logic [V_W-1:0] b,
  input  logic [H_W-1:0] xo,
  input  logic [V_W-1:0] yo,
  input  logic           cal,
  output logic           present,
  output logic [H_W-1:0] x,
  output logic [V_W-1:0] y
);

  function automatic logic [H_W-1:0] clamp_h(input logic signed [H_W+1:0] d);
    if (d < 0) return '0;
    return d[H_W-1:0];
  endfunction

  function automatic logic [V_W-1:0] clamp_v(input logic signed [V_W+1:0] d);
    if (d < 0) return '0;
    return d[V_W-1:0];
  endfunction

  logic        [H_W-1:0] cx;
  logic        [V_W-1:0] cy;
  logic signed [H_W+1:0] dx;
  logic signed [V_W+1:0] dy;

  // Sums carry one extra bit so wide zones near the right/bottom edge keep their MSB.
  assign cx = H_W'(({1'b0, l} + {1'b0, r}) >> 1);
  assign cy = V_W'(({1'b0, t} + {1'b0, b}) >> 1);
  assign dx = $signed({2'b00, cx}) - $signed({2'b00, xo});
  assign dy = $signed({2'b00, cy}) - $signed({2'b00, yo});

  assign present = (r > l) && (b > t);

  always_comb begin
    x = '0;
    y = '0;
    if (present) begin
      x = cal ? clamp_h(dx) : cx;
      y = cal ? clamp_v(dy) : cy;
    end
  end

endmodule

// File: rtl/zone_reader.sv
// Per-frame snapshot of four tracker zones, streamed as valid/ready records.
// Optional build macro: ZONE_SMOOTH_EN (per-zone two-tap coordinate smoothing).
module zone_reader
  import zone_reader_pkg::*;
#(
  parameter int SNAP_V = 600,
  parameter int SNAP_H = 0,
  parameter int NZ     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [H_W-1:0]    hcount,
  input  logic [V_W-1:0]    vcount,
  input  logic              calibrated,
  input  logic [H_W-1:0]    xo,
  input  logic [V_W-1:0]    yo,
  input  logic [HOR_W-1:0]  hor1,
  input  logic [HOR_W-1:0]  hor2,
  input  logic [HOR_W-1:0]  hor3,
  input  logic [HOR_W-1:0]  hor4,
  input  logic [VERT_W-1:0] vert1,
  input  logic [VERT_W-1:0] vert2,
  input  logic [VERT_W-1:0] vert3,
  input  logic [VERT_W-1:0] vert4,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [ZIDX_W-1:0] out_zone,
  output logic              out_present,
  output logic [H_W-1:0]    out_x,
  output logic [V_W-1:0]    out_y,
  output logic              frame_done,
  output logic              overrun
);

  localparam logic [ZIDX_W-1:0] LAST_IDX = ZIDX_W'(NZ - 1);

  state_t              state, nstate;
  logic                trig_p0, trig_p1, trig_edge;
  logic [ZIDX_W-1:0]   idx;
  logic                do_snap, do_calc, accept, last_rec;

  logic [HOR_W-1:0]    hor_p1  [ZN];
  logic [VERT_W-1:0]   vert_p1 [ZN];
  logic [H_W-1:0]      xo_p1;
  logic [V_W-1:0]      yo_p1;
  logic                cal_p1;

  logic [HOR_W-1:0]    sel_hor;
  logic [VERT_W-1:0]   sel_vert;
  logic                zc_present;
  logic [H_W-1:0]      zc_x, sm_x;
  logic [V_W-1:0]      zc_y, sm_y;

  assign trig_edge = trig_p0 & ~trig_p1;
  assign last_rec  = (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate  = state;
    do_snap = 1'b0;
    do_calc = 1'b0;
    accept  = 1'b0;
    case (state)
      IDLE: if (trig_edge) nstate = SNAP;
      SNAP: begin
        do_snap = 1'b1;
        nstate  = CALC;
      end
      CALC: begin
        do_calc = 1'b1;
        nstate  = EMIT;
      end
      EMIT: if (out_valid && out_ready) begin
        accept = 1'b1;
        nstate = last_rec ? IDLE : CALC;
      end
      default: nstate = IDLE;
    endcase
  end

  // Stage p1: frame snapshot, selected zone routed into the centre calculator
  assign sel_hor  = hor_p1[idx];
  assign sel_vert = vert_p1[idx];

  zone_centre u_centre (
    .l       (hor_left(sel_hor)),
    .r       (hor_right(sel_hor)),
    .t       (vert_top(sel_vert)),
    .b       (vert_bottom(sel_vert)),
    .xo      (xo_p1),
    .yo      (yo_p1),
    .cal     (cal_p1),
    .present (zc_present),
    .x       (zc_x),
    .y       (zc_y)
  );

`ifdef ZONE_SMOOTH_EN
  function automatic logic [H_W-1:0] avg_h(input logic [H_W-1:0] a, input logic [H_W-1:0] b);
    return H_W'(({1'b0, a} + {1'b0, b}) >> 1);
  endfunction

  function automatic logic [V_W-1:0] avg_v(input logic [V_W-1:0] a, input logic [V_W-1:0] b);
    return V_W'(({1'b0, a} + {1'b0, b}) >> 1);
  endfunction

  logic [H_W-1:0] hx [ZN];
  logic [V_W-1:0] hy [ZN];
  logic [ZN-1:0]  hvalid;

  always_comb begin
    sm_x = zc_x;
    sm_y = zc_y;
    if (zc_present && hvalid[idx]) begin
      sm_x = avg_h(hx[idx], zc_x);
      sm_y = avg_v(hy[idx], zc_y);
    end
  end

  // Absent zones leave their history untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ZN; i++) begin
        hx[i] <= '0;
        hy[i] <= '0;
      end
      hvalid <= '0;
    end else if (do_calc && zc_present) begin
      hx[idx]     <= sm_x;
      hy[idx]     <= sm_y;
      hvalid[idx] <= 1'b1;
    end
  end
`else
  assign sm_x = zc_x;
  assign sm_y = zc_y;
`endif

  // Stage p2: record registers held until the consumer accepts
  always_ff @(posedge clk) begin
    if (reset) begin
      trig_p0     <= 1'b0;
      trig_p1     <= 1'b0;
      idx         <= '0;
      for (int i = 0; i < ZN; i++) begin
        hor_p1[i]  <= '0;
        vert_p1[i] <= '0;
      end
      xo_p1       <= '0;
      yo_p1       <= '0;
      cal_p1      <= 1'b0;
      out_valid   <= 1'b0;
      out_zone    <= '0;
      out_present <= 1'b0;
      out_x       <= '0;
      out_y       <= '0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      trig_p0    <= (hcount == H_W'(SNAP_H)) && (vcount == V_W'(SNAP_V));
      trig_p1    <= trig_p0;
      frame_done <= accept && last_rec;
      if (trig_edge && (state != IDLE)) overrun <= 1'b1;
      if (do_snap) begin
        hor_p1[0]  <= hor1;
        hor_p1[1]  <= hor2;
        hor_p1[2]  <= hor3;
        hor_p1[3]  <= hor4;
        vert_p1[0] <= vert1;
        vert_p1[1] <= vert2;
        vert_p1[2] <= vert3;
        vert_p1[3] <= vert4;
        xo_p1      <= xo;
        yo_p1      <= yo;
        cal_p1     <= calibrated;
        idx        <= '0;
      end
      if (do_calc) begin
        out_valid   <= 1'b1;
        out_zone    <= idx;
        out_present <= zc_present;
        out_x       <= sm_x;
        out_y       <= sm_y;
      end
      if (accept) begin
        out_valid <= 1'b0;
        if (!last_rec) idx <= idx + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_zone_reader.sv
// Directed bench for zone_reader with a scoreboard of expected zone records.
module tb_zone_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        calibrated;
  logic [10:0] xo;
  logic [9:0]  yo;
  logic [21:0] hor1, hor2, hor3, hor4;
  logic [19:0] vert1, vert2, vert3, vert4;
  logic        out_ready;
  logic        out_valid;
  logic [1:0]  out_zone;
  logic        out_present;
  logic [10:0] out_x;
  logic [9:0]  out_y;
  logic        frame_done;
  logic        overrun;

  logic [10:0] bl [4];
  logic [10:0] br [4];
  logic [9:0]  bt [4];
  logic [9:0]  bb [4];

  assign hor1  = {bl[0], br[0]};
  assign hor2  = {bl[1], br[1]};
  assign hor3  = {bl[2], br[2]};
  assign hor4  = {bl[3], br[3]};
  assign vert1 = {bt[0], bb[0]};
  assign vert2 = {bt[1], bb[1]};
  assign vert3 = {bt[2], bb[2]};
  assign vert4 = {bt[3], bb[3]};

  always #5 clk = ~clk;

  zone_reader dut (
    .clk         (clk),
    .reset       (reset),
    .hcount      (hcount),
    .vcount      (vcount),
    .calibrated  (calibrated),
    .xo          (xo),
    .yo          (yo),
    .hor1        (hor1),
    .hor2        (hor2),
    .hor3        (hor3),
    .hor4        (hor4),
    .vert1       (vert1),
    .vert2       (vert2),
    .vert3       (vert3),
    .vert4       (vert4),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_zone    (out_zone),
    .out_present (out_present),
    .out_x       (out_x),
    .out_y       (out_y),
    .frame_done  (frame_done),
    .overrun     (overrun)
  );

  typedef struct {
    int zone;
    int present;
    int x;
    int y;
  } rec_t;

  rec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   fd_cnt = 0;
  int   rec_in_frame = 0;
  int   hx [4];
  int   hy [4];
  int   hv [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_zone(input int z, input int l, input int r, input int t, input int b);
    bl[z] = 11'(l);
    br[z] = 11'(r);
    bt[z] = 10'(t);
    bb[z] = 10'(b);
  endtask

  task automatic clear_model();
    exp_q.delete();
    rec_in_frame = 0;
    for (int z = 0; z < 4; z++) begin
      hx[z] = 0;
      hy[z] = 0;
      hv[z] = 0;
    end
  endtask

  // Expected records for the bounds currently driven (taken as the snapshot).
  task automatic push_frame();
    rec_t e;
    for (int z = 0; z < 4; z++) begin
      int l, r, t, b, x, y;
      l = int'(bl[z]);
      r = int'(br[z]);
      t = int'(bt[z]);
      b = int'(bb[z]);
      e.zone = z;
      e.present = (r > l && b > t) ? 1 : 0;
      x = 0;
      y = 0;
      if (e.present == 1) begin
        x = (l + r) / 2;
        y = (t + b) / 2;
        if (calibrated) begin
          x = x - int'(xo);
          y = y - int'(yo);
          if (x < 0) x = 0;
          if (y < 0) y = 0;
        end
`ifdef ZONE_SMOOTH_EN
        if (hv[z] == 1) begin
          x = (hx[z] + x) / 2;
          y = (hy[z] + y) / 2;
        end
        hx[z] = x;
        hy[z] = y;
        hv[z] = 1;
`endif
      end
      e.x = x;
      e.y = y;
      exp_q.push_back(e);
    end
  endtask

  task automatic fire_trig();
    step(1);
    hcount = 11'd0;
    vcount = 10'd600;
    step(1);
    hcount = 11'd7;
    vcount = 10'd0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, out_valid, 1);
  endtask

  task automatic wait_zone(input string tag, input int z);
    int n;
    n = 0;
    @(negedge clk);
    while (!(out_valid === 1'b1 && int'(out_zone) == z) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, out_zone, z);
  endtask

  task automatic wait_frame(input string tag);
    int n, start;
    n = 0;
    start = fd_cnt;
    while (fd_cnt == start && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, fd_cnt, start + 1);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          rec_t e;
          e = exp_q.pop_front();
          chk("rec_zone", out_zone, e.zone);
          chk("rec_present", out_present, e.present);
          chk("rec_x", out_x, e.x);
          chk("rec_y", out_y, e.y);
        end
        rec_in_frame++;
      end
      if (frame_done === 1'b1) begin
        fd_cnt++;
        chk("recs_per_frame", rec_in_frame, 4);
        rec_in_frame = 0;
      end
    end
  end

  initial begin
    int fd_before;
    reset = 1'b1;
    hcount = 11'd7;
    vcount = 10'd0;
    calibrated = 1'b0;
    xo = '0;
    yo = '0;
    out_ready = 1'b0;
    for (int z = 0; z < 4; z++) set_zone(z, 0, 0, 0, 0);
    clear_model();
    step(3);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_x", out_x, 0);
    chk("rst_y", out_y, 0);
    chk("rst_present", out_present, 0);
    step(1);
    reset = 1'b0;
    step(3);

    // 1: uncalibrated single zone, latency of first record
    set_zone(0, 100, 120, 200, 210);
    out_ready = 1'b1;
    fd_before = fd_cnt;
    push_frame();
    fire_trig();
    repeat (3) begin
      @(negedge clk);
      chk("lat_early_valid", out_valid, 0);
    end
    @(negedge clk);
    chk("lat_first_valid", out_valid, 1);
    chk("lat_first_zone", out_zone, 0);
    wait_frame("t1_frame");
    step(10);
    chk("t1_done_once", fd_cnt, fd_before + 1);

    // 2: calibrated with clamp, equal bounds and full-range bounds
    calibrated = 1'b1;
    xo = 11'd50;
    yo = 10'd80;
    set_zone(0, 30, 50, 100, 120);
    set_zone(1, 60, 80, 90, 100);
    set_zone(2, 500, 500, 10, 20);
    set_zone(3, 2000, 2047, 1000, 1023);
    push_frame();
    fire_trig();
    wait_frame("t2_frame");
    step(3);

    // 3: consumer stalls; record must hold, later bound changes must not leak in
    calibrated = 1'b0;
    set_zone(0, 10, 30, 5, 15);
    set_zone(1, 0, 2047, 0, 1023);
    set_zone(2, 300, 299, 10, 20);
    set_zone(3, 700, 702, 400, 400);
    out_ready = 1'b0;
    push_frame();
    fire_trig();
    wait_valid("t3_valid");
    set_zone(0, 900, 1000, 600, 700);
    set_zone(1, 1, 3, 1, 3);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_zone", out_zone, exp_q[0].zone);
      chk("stall_x", out_x, exp_q[0].x);
      chk("stall_y", out_y, exp_q[0].y);
    end
    step(1);
    out_ready = 1'b1;
    wait_frame("t3_frame");
    step(3);

    // 4: second trigger while busy is dropped and flags overrun
    out_ready = 1'b0;
    fd_before = fd_cnt;
    push_frame();
    fire_trig();
    wait_valid("t4_valid");
    chk("t4_no_overrun_yet", overrun, 0);
    fire_trig();
    step(1);
    @(negedge clk);
    chk("t4_overrun_set", overrun, 1);
    step(1);
    out_ready = 1'b1;
    wait_frame("t4_frame");
    step(30);
    chk("t4_overrun_sticky", overrun, 1);
    chk("t4_queue_empty", exp_q.size(), 0);
    chk("t4_one_frame", fd_cnt, fd_before + 1);

    // 5: reset while zone 2 is waiting, then a clean restart
    push_frame();
    fire_trig();
    wait_zone("t5_zone1", 1);
    step(1);
    out_ready = 1'b0;
    wait_zone("t5_zone2", 2);
    fd_before = fd_cnt;
    step(1);
    reset = 1'b1;
    step(1);
    @(negedge clk);
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_overrun", overrun, 0);
    chk("t5_rst_done", frame_done, 0);
    step(1);
    reset = 1'b0;
    clear_model();
    step(5);
    chk("t5_no_done", fd_cnt, fd_before);
    out_ready = 1'b1;
    push_frame();
    fire_trig();
    wait_valid("t5_restart_valid");
    chk("t5_restart_zone", out_zone, 0);
    wait_frame("t5_frame");

    // 6: history across present / absent / present frames
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    clear_model();
    for (int z = 0; z < 4; z++) set_zone(z, 0, 0, 0, 0);
    set_zone(0, 90, 110, 50, 60);
    push_frame();
    fire_trig();
    wait_frame("t6_frame_a");
    set_zone(0, 0, 0, 0, 0);
    push_frame();
    fire_trig();
    wait_frame("t6_frame_b");
    set_zone(0, 110, 130, 50, 60);
    push_frame();
    fire_trig();
    wait_frame("t6_frame_c");
    step(5);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
